vga_line_sched: RTL and testbench

//  Ping-pong capture scheduler between the OV pixel stream and the VGA line RAM.

---
 rtl/vga_line_sched.sv | 207 ++++++++++++++++++++
 tb/tb_vga_line_sched.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_line_sched.sv
// vga_line_sched: captures one selected sensor line into a ping-pong pair of
// line-RAM banks, packing byte pairs into 16-bit words, and hands completed
// banks to the VGA reader through a req/ack/done handshake. A bank that is
// being filled or read is never offered to the other side.
module vga_line_sched #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 320,
  parameter int TO_US     = 40000
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic              pluse_us,
  input  logic [15:0]       cfg_line,
  input  logic              cfg_arm,
  input  logic              cfg_cont,
  input  logic [15:0]       num_line,
  input  logic [15:0]       num_pclk,
  input  logic [7:0]        data_pclk,
  input  logic              data_vld,
  output logic [15:0]       ram_wdata,
  output logic [ADDR_W:0]   ram_waddr,
  output logic              ram_wren,
  input  logic              rd_req,
  output logic              rd_ack,
  output logic              rd_bank,
  input  logic              rd_done,
  output logic              cap_busy,
  output logic              cap_done,
  output logic              cap_err,
  output logic [ADDR_W:0]   word_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAP, S_COMMIT} state_t;

  localparam logic [1:0] B_FREE = 2'd0;
  localparam logic [1:0] B_FILL = 2'd1;
  localparam logic [1:0] B_FULL = 2'd2;
  localparam logic [1:0] B_READ = 2'd3;

  localparam int              TO_W    = $clog2(TO_US + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_US - 1);
  localparam logic [ADDR_W:0] MAX_W   = (ADDR_W + 1)'(MAX_WORDS);

  state_t            state_q, state_d;
  logic [1:0]        bank_q [2];
  logic [1:0]        bank_d [2];
  logic              cur_bank_q;
  logic              older_q;
  logic [7:0]        hi_q;
  logic [ADDR_W:0]   wcnt_q;
  logic [ADDR_W:0]   word_cnt_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic              wren_q;
  logic [ADDR_W:0]   waddr_q;
  logic [15:0]       wdata_q;
  logic              rd_ack_q;
  logic              rd_bank_q;
  logic              cap_err_q;

  // Decodes shared by the FSM, datapath and bank bookkeeping
  logic line_hit, line_end, free_any, pick_bank, start_hit;
  logic odd_wr, last_word, to_fire, enter_cap, do_write;
  logic full0, full1, none_read, grant, grant_bank;

  assign line_hit   = data_vld && (num_line == cfg_line);
  assign line_end   = data_vld && (num_line != cfg_line);
  assign free_any   = (bank_q[0] == B_FREE) || (bank_q[1] == B_FREE);
  assign pick_bank  = (bank_q[0] == B_FREE) ? 1'b0 : 1'b1;
  assign start_hit  = line_hit && (num_pclk == '0) && free_any;
  assign odd_wr     = (state_q == S_CAP) && line_hit && num_pclk[0];
  assign last_word  = odd_wr && ((wcnt_q + 1'b1) == MAX_W);
  assign to_fire    = ((state_q == S_WAIT) || (state_q == S_CAP)) && pluse_us &&
                      (to_cnt_q == TO_LAST);
  assign enter_cap  = (state_q == S_WAIT) && (state_d == S_CAP);
  assign do_write   = odd_wr && !to_fire;

  // Reader side: only one bank may be out for reading at a time; when both
  // are full the one committed first goes out first.
  assign full0      = (bank_q[0] == B_FULL);
  assign full1      = (bank_q[1] == B_FULL);
  assign none_read  = (bank_q[0] != B_READ) && (bank_q[1] != B_READ);
  assign grant      = rd_req && none_read && (full0 || full1);
  assign grant_bank = (full0 && full1) ? older_q : full1;

  // FSM state register
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic; timeout has priority over line events
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (cfg_arm) state_d = S_WAIT;
      S_WAIT: begin
        if (to_fire)        state_d = S_IDLE;
        else if (start_hit) state_d = S_CAP;
      end
      S_CAP: begin
        if (to_fire)                     state_d = S_IDLE;
        else if (line_end || last_word)  state_d = S_COMMIT;
      end
      S_COMMIT: state_d = cfg_cont ? S_WAIT : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs decoded from the state register
  always_comb begin
    cap_busy = (state_q != S_IDLE);
    cap_done = (state_q == S_COMMIT);
  end

  // Capture datapath: byte pairing, RAM write port, word counting
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      wren_q     <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      hi_q       <= '0;
      wcnt_q     <= '0;
      word_cnt_q <= '0;
      cur_bank_q <= 1'b0;
      cap_err_q  <= 1'b0;
    end else begin
      wren_q    <= do_write;
      cap_err_q <= to_fire;
      if (do_write) begin
        waddr_q <= {cur_bank_q, num_pclk[ADDR_W:1]};
        wdata_q <= {hi_q, data_pclk};
        wcnt_q  <= wcnt_q + 1'b1;
      end
      if (enter_cap) begin
        cur_bank_q <= pick_bank;
        hi_q       <= data_pclk;
        wcnt_q     <= '0;
      end else if ((state_q == S_CAP) && line_hit && !num_pclk[0]) begin
        hi_q <= data_pclk;
      end
      if (state_q == S_COMMIT) word_cnt_q <= wcnt_q;
    end
  end

  // Timeout counter: cleared on entering WAIT_LINE, counts us ticks while waiting/capturing
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else if ((state_d == S_WAIT) && (state_q != S_WAIT)) begin
      to_cnt_q <= '0;
    end else if (((state_q == S_WAIT) || (state_q == S_CAP)) && pluse_us) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  // Bank lifecycle; at most one event can hit a given bank in a cycle
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      bank_d[i] = bank_q[i];
      if (enter_cap && (pick_bank == 1'(i)))
        bank_d[i] = B_FILL;
      if ((state_q == S_COMMIT) && (cur_bank_q == 1'(i)))
        bank_d[i] = B_FULL;
      if (to_fire && (state_q == S_CAP) && (cur_bank_q == 1'(i)))
        bank_d[i] = B_FREE;
      if (grant && (grant_bank == 1'(i)))
        bank_d[i] = B_READ;
      if (rd_done && (bank_q[i] == B_READ))
        bank_d[i] = B_FREE;
    end
  end

  // Bank state registers
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      bank_q[0] <= B_FREE;
      bank_q[1] <= B_FREE;
    end else begin
      bank_q[0] <= bank_d[0];
      bank_q[1] <= bank_d[1];
    end
  end

  // Reader handshake and full-bank age ordering
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      rd_ack_q  <= 1'b0;
      rd_bank_q <= 1'b0;
      older_q   <= 1'b0;
    end else begin
      rd_ack_q <= grant;
      if (grant) rd_bank_q <= grant_bank;
      // a bank committing while its partner is already full is the younger one
      if (state_q == S_COMMIT)
        older_q <= (bank_q[~cur_bank_q] == B_FULL) ? ~cur_bank_q : cur_bank_q;
    end
  end

  assign ram_wren  = wren_q;
  assign ram_waddr = waddr_q;
  assign ram_wdata = wdata_q;
  assign rd_ack    = rd_ack_q;
  assign rd_bank   = rd_bank_q;
  assign cap_err   = cap_err_q;
  assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_vga_line_sched.sv
// Directed bench for vga_line_sched: RAM writes are checked against a queue of
// expected {addr,data} words pushed as the bytes are driven.
module tb_vga_line_sched;
  localparam int ADDR_W = 10;
  localparam int TO_US  = 50;

  logic              clk_sys = 1'b0;
  logic              rst;
  logic              pluse_us;
  logic [15:0]       cfg_line;
  logic              cfg_arm;
  logic              cfg_cont;
  logic [15:0]       num_line;
  logic [15:0]       num_pclk;
  logic [7:0]        data_pclk;
  logic              data_vld;
  logic [15:0]       ram_wdata;
  logic [ADDR_W:0]   ram_waddr;
  logic              ram_wren;
  logic              rd_req;
  logic              rd_ack;
  logic              rd_bank;
  logic              rd_done;
  logic              cap_busy;
  logic              cap_done;
  logic              cap_err;
  logic [ADDR_W:0]   word_cnt;

  always #5 clk_sys = ~clk_sys;

  vga_line_sched #(.ADDR_W(ADDR_W), .MAX_WORDS(320), .TO_US(TO_US)) dut (
    .clk_sys(clk_sys), .rst(rst), .pluse_us(pluse_us),
    .cfg_line(cfg_line), .cfg_arm(cfg_arm), .cfg_cont(cfg_cont),
    .num_line(num_line), .num_pclk(num_pclk), .data_pclk(data_pclk), .data_vld(data_vld),
    .ram_wdata(ram_wdata), .ram_waddr(ram_waddr), .ram_wren(ram_wren),
    .rd_req(rd_req), .rd_ack(rd_ack), .rd_bank(rd_bank), .rd_done(rd_done),
    .cap_busy(cap_busy), .cap_done(cap_done), .cap_err(cap_err), .word_cnt(word_cnt)
  );

  logic [26:0] sb [$];
  int          n_cmp = 0;
  int          n_mis = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          ack_cnt = 0;
  logic        ack_bank = 1'b0;
  logic        exp_wren = 1'b0;
  logic [7:0]  hi_byte = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // one clock; sample 1 ns after the edge, check the write port, log pulses
  task automatic tick();
    logic [26:0] got, expw;
    @(posedge clk_sys);
    #1;
    check("ram_wren", 32'(ram_wren), 32'(exp_wren));
    exp_wren = 1'b0;
    if (ram_wren) begin
      got = {ram_waddr, ram_wdata};
      if (sb.size() == 0) expw = ~got;
      else                expw = sb.pop_front();
      check("ram_write", 32'(got), 32'(expw));
      $display("write addr=0x%03h data=0x%04h", ram_waddr, ram_wdata);
    end
    if (cap_done) done_cnt++;
    if (cap_err)  err_cnt++;
    if (rd_ack) begin
      ack_cnt++;
      ack_bank = rd_bank;
      $display("rd_ack bank=%0d", rd_bank);
    end
  endtask

  task automatic arm();
    cfg_arm = 1'b1;
    tick();
    cfg_arm = 1'b0;
  endtask

  // bytes 0..n-1 of a line, value = index & 0x7F; exp=1 when the DUT should store them
  task automatic send_line(input logic [15:0] line, input int nbytes, input bit exp, input logic bank);
    logic [7:0] b;
    for (int i = 0; i < nbytes; i++) begin
      b         = 8'(i) & 8'h7F;
      data_vld  = 1'b1;
      num_line  = line;
      num_pclk  = 16'(i);
      data_pclk = b;
      if (exp) begin
        if ((i % 2) == 0) begin
          hi_byte = b;
        end else begin
          sb.push_back({bank, 10'(i / 2), hi_byte, b});
          exp_wren = 1'b1;
        end
      end
      tick();
    end
    data_vld = 1'b0;
  endtask

  task automatic end_line(input logic [15:0] line);
    data_vld  = 1'b1;
    num_line  = line + 16'd1;
    num_pclk  = 16'd0;
    data_pclk = 8'hEE;
    tick();
    data_vld = 1'b0;
    tick();
    tick();
  endtask

  task automatic pulse_done();
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
  endtask

  task automatic us_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      pluse_us = 1'b1;
      tick();
      pluse_us = 1'b0;
      tick();
    end
  endtask

  task automatic wait_ack(input string tag);
    int a0;
    a0 = ack_cnt;
    for (int k = 0; k < 8 && ack_cnt == a0; k++) tick();
    check(tag, 32'(ack_cnt - a0), 32'd1);
  endtask

  task automatic reset_chk(input string tag);
    check({tag, "_wren"},  32'(ram_wren),  32'd0);
    check({tag, "_wdata"}, 32'(ram_wdata), 32'd0);
    check({tag, "_waddr"}, 32'(ram_waddr), 32'd0);
    check({tag, "_ack"},   32'(rd_ack),    32'd0);
    check({tag, "_bank"},  32'(rd_bank),   32'd0);
    check({tag, "_busy"},  32'(cap_busy),  32'd0);
    check({tag, "_done"},  32'(cap_done),  32'd0);
    check({tag, "_err"},   32'(cap_err),   32'd0);
    check({tag, "_wcnt"},  32'(word_cnt),  32'd0);
  endtask

  initial begin
    int a0;
    rst = 1'b1; pluse_us = 1'b0; cfg_line = 16'd240; cfg_arm = 1'b0; cfg_cont = 1'b0;
    num_line = '0; num_pclk = '0; data_pclk = '0; data_vld = 1'b0;
    rd_req = 1'b0; rd_done = 1'b0;
    tick();
    tick();
    reset_chk("reset");
    rst = 1'b0;
    tick();

    // full 640-byte line into bank 0, ends on the word limit
    arm();
    send_line(16'd240, 640, 1'b1, 1'b0);
    end_line(16'd240);
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    check("t1_word_cnt", 32'(word_cnt), 32'd320);
    check("t1_busy", 32'(cap_busy), 32'd0);
    check("t1_sb_empty", 32'(sb.size()), 32'd0);

    // grant bank 0; held request must not re-grant; next capture uses bank 1
    rd_req = 1'b1;
    wait_ack("t2_ack0");
    check("t2_ack0_bank", 32'(ack_bank), 32'd0);
    a0 = ack_cnt;
    tick(); tick(); tick();
    check("t2_no_regrant", 32'(ack_cnt - a0), 32'd0);
    arm();
    send_line(16'd240, 7, 1'b1, 1'b1);
    end_line(16'd240);
    check("t2_done_cnt", 32'(done_cnt), 32'd2);
    check("t2_word_cnt", 32'(word_cnt), 32'd3);
    check("t2_no_grant_while_reading", 32'(ack_cnt - a0), 32'd0);
    pulse_done();
    wait_ack("t2_ack1");
    check("t2_ack1_bank", 32'(ack_bank), 32'd1);
    pulse_done();
    rd_req = 1'b0;
    pulse_done();
    tick();

    // continuous mode, nobody reading: third frame must stall
    cfg_cont = 1'b1;
    arm();
    send_line(16'd240, 8, 1'b1, 1'b0);
    end_line(16'd240);
    send_line(16'd240, 8, 1'b1, 1'b1);
    end_line(16'd240);
    send_line(16'd240, 8, 1'b0, 1'b0);
    end_line(16'd240);
    check("t3_done_cnt", 32'(done_cnt), 32'd4);
    check("t3_stall_busy", 32'(cap_busy), 32'd1);
    check("t3_sb_empty", 32'(sb.size()), 32'd0);
    rd_req = 1'b1;
    wait_ack("t3_ack_oldest");
    check("t3_oldest_bank", 32'(ack_bank), 32'd0);
    rd_req = 1'b0;
    tick();
    cfg_cont = 1'b0;
    pulse_done();
    send_line(16'd240, 8, 1'b1, 1'b0);
    end_line(16'd240);
    check("t3_done_cnt4", 32'(done_cnt), 32'd5);
    check("t3_idle", 32'(cap_busy), 32'd0);
    check("t3_word_cnt", 32'(word_cnt), 32'd4);
    rd_req = 1'b1;
    wait_ack("t3_ack_older1");
    check("t3_older_bank1", 32'(ack_bank), 32'd1);
    rd_req = 1'b0;
    tick();

    // timeouts: waiting for an absent line, then mid-capture
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    cfg_line = 16'd300;
    arm();
    us_ticks(TO_US - 1);
    check("t4_no_err_early", 32'(err_cnt), 32'd0);
    check("t4_busy_wait", 32'(cap_busy), 32'd1);
    us_ticks(1);
    check("t4_err", 32'(err_cnt), 32'd1);
    check("t4_idle", 32'(cap_busy), 32'd0);
    cfg_line = 16'd240;
    arm();
    send_line(16'd240, 4, 1'b1, 1'b0);
    end_line(16'd240);
    check("t4_word_cnt", 32'(word_cnt), 32'd2);
    arm();
    send_line(16'd240, 4, 1'b1, 1'b1);
    check("t4_busy_cap", 32'(cap_busy), 32'd1);
    us_ticks(TO_US);
    check("t4_err2", 32'(err_cnt), 32'd2);
    check("t4_word_cnt_kept", 32'(word_cnt), 32'd2);
    check("t4_idle2", 32'(cap_busy), 32'd0);
    arm();
    send_line(16'd240, 6, 1'b1, 1'b1);
    end_line(16'd240);
    check("t4_refill_wcnt", 32'(word_cnt), 32'd3);

    // reset in the middle of a line
    rd_req = 1'b1;
    wait_ack("t5_ack");
    check("t5_ack_bank", 32'(ack_bank), 32'd0);
    rd_req = 1'b0;
    pulse_done();
    arm();
    send_line(16'd240, 4, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    reset_chk("rst_mid");
    tick();
    rst = 1'b0;
    tick();
    arm();
    send_line(16'd240, 4, 1'b1, 1'b0);
    end_line(16'd240);
    check("t5_word_cnt", 32'(word_cnt), 32'd2);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
